dif_radix2_64p_da_ctrl: RTL and testbench

//  Sequencer for the 64-point radix-2 DIF data arranger (8 banks x 8 entries). Accepts one
//  64-sample frame from the last butterfly stage, generating wen_ctrl/waddr_ctrl so each

---
 rtl/dif_radix2_64p_da_ctrl.sv | 172 +++++++++++++++++
 tb/tb_dif_radix2_64p_da_ctrl.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/dif_radix2_64p_da_ctrl.sv
// dif_radix2_64p_da_ctrl
//   Sequencer for the 64-point radix-2 DIF data arranger (8 banks x 8 entries).
//   One 64-sample frame is written in arrival order (index w -> bank w[5:3],
//   addr w[2:0]), then drained in the frame's output order: bit-reversed to
//   natural (mode 0) or bank/address transpose (mode 1).
//
//   Handshake: a sample is transferred on a rising edge where in_valid and
//   in_ready are both high. in_ready depends only on the state register, so
//   in_valid never feeds in_ready combinationally. in_valid while in_ready is
//   low drops the sample and sets the sticky overrun flag.
//
// Ports
//   clk, rst_n             clock, asynchronous active-low reset
//   in_valid / in_ready    upstream sample handshake
//   mode                   output order, latched on the first write of a frame
//   wen_ctrl, waddr_ctrl   arranger write bank (4'd8 = none) and address (combinational)
//   ren_ctrl, raddr_ctrl   arranger read bank (4'd8 = none) and address (registered)
//   dout_valid/first/last  arranger output qualifiers, RD_LAT after the read
//   busy                   frame in progress (state != IDLE)
//   overrun                sticky dropped-sample flag, cleared only by reset
//   dbg_state              current FSM state (0 IDLE, 1 FILL, 2 DRAIN, 3 FLUSH)
module dif_radix2_64p_da_ctrl #(
  parameter int FRAME_LEN = 64,
  parameter int RD_LAT    = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       mode,
  output logic [3:0] wen_ctrl,
  output logic [2:0] waddr_ctrl,
  output logic [3:0] ren_ctrl,
  output logic [2:0] raddr_ctrl,
  output logic       dout_valid,
  output logic       dout_first,
  output logic       dout_last,
  output logic       busy,
  output logic       overrun,
  output logic [1:0] dbg_state
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_FILL = 2'd1, S_DRAIN = 2'd2, S_FLUSH = 2'd3} state_e;

  localparam logic [5:0] LAST_IDX = 6'(FRAME_LEN - 1);
  localparam int         CW       = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [CW-1:0] FL_LAST = CW'(RD_LAT - 1);

  state_e          state_q, state_d;
  logic [5:0]      w_q, w_d;
  logic [5:0]      r_q, r_d;
  logic            mode_q, mode_d;
  logic [CW-1:0]   fl_q, fl_d;
  logic [3:0]      ren_q, ren_d;
  logic [2:0]      raddr_q, raddr_d;
  logic            overrun_q;
  logic            accept;
  logic [5:0]      rd_loc;
  logic [RD_LAT-1:0] vld_sr_q, fst_sr_q, lst_sr_q;

  // Arranger location holding output index r.
  function automatic logic [5:0] loc_of(input logic m, input logic [5:0] r);
    logic [5:0] rev;
    for (int i = 0; i < 6; i++) rev[i] = r[5-i];
    return m ? {r[2:0], r[5:3]} : rev;
  endfunction

  // State register and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      w_q       <= '0;
      r_q       <= '0;
      mode_q    <= 1'b0;
      fl_q      <= '0;
      ren_q     <= 4'd8;
      raddr_q   <= 3'd0;
      overrun_q <= 1'b0;
      vld_sr_q  <= '0;
      fst_sr_q  <= '0;
      lst_sr_q  <= '0;
    end else begin
      state_q   <= state_d;
      w_q       <= w_d;
      r_q       <= r_d;
      mode_q    <= mode_d;
      fl_q      <= fl_d;
      ren_q     <= ren_d;
      raddr_q   <= raddr_d;
      overrun_q <= overrun_q | (in_valid & ~in_ready);
      // Issue-time flags travel alongside the read data through the arranger.
      vld_sr_q[0] <= (state_q == S_DRAIN);
      fst_sr_q[0] <= (state_q == S_DRAIN) && (r_q == 6'd0);
      lst_sr_q[0] <= (state_q == S_DRAIN) && (r_q == LAST_IDX);
      for (int i = 1; i < RD_LAT; i++) begin
        vld_sr_q[i] <= vld_sr_q[i-1];
        fst_sr_q[i] <= fst_sr_q[i-1];
        lst_sr_q[i] <= lst_sr_q[i-1];
      end
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    w_d     = w_q;
    r_d     = r_q;
    mode_d  = mode_q;
    fl_d    = fl_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          w_d     = 6'd1;
          mode_d  = mode;
          state_d = S_FILL;
        end
      end
      S_FILL: begin
        if (accept) begin
          if (w_q == LAST_IDX) begin
            w_d     = 6'd0;
            r_d     = 6'd0;
            state_d = S_DRAIN;
          end else begin
            w_d = w_q + 6'd1;
          end
        end
      end
      S_DRAIN: begin
        if (r_q == LAST_IDX) begin
          r_d     = 6'd0;
          fl_d    = '0;
          state_d = S_FLUSH;
        end else begin
          r_d = r_q + 6'd1;
        end
      end
      S_FLUSH: begin
        if (fl_q == FL_LAST) begin
          fl_d    = '0;
          state_d = S_IDLE;
        end else begin
          fl_d = fl_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // The read port is registered from the next state/index so that the
    // cycle spent in DRAIN with index r presents the read for r.
    rd_loc  = loc_of(mode_q, r_d);
    ren_d   = (state_d == S_DRAIN) ? {1'b0, rd_loc[5:3]} : 4'd8;
    raddr_d = (state_d == S_DRAIN) ? rd_loc[2:0] : 3'd0;
  end

  // Output decode
  always_comb begin
    in_ready   = (state_q == S_IDLE) || (state_q == S_FILL);
    busy       = (state_q != S_IDLE);
    accept     = in_valid & in_ready;
    wen_ctrl   = accept ? {1'b0, w_q[5:3]} : 4'd8;
    waddr_ctrl = w_q[2:0];
    ren_ctrl   = ren_q;
    raddr_ctrl = raddr_q;
    dout_valid = vld_sr_q[RD_LAT-1];
    dout_first = fst_sr_q[RD_LAT-1];
    dout_last  = lst_sr_q[RD_LAT-1];
    overrun    = overrun_q;
    dbg_state  = state_q;
  end

endmodule

// File: tb/tb_dif_radix2_64p_da_ctrl.sv
module tb_dif_radix2_64p_da_ctrl;
  localparam int W = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic         in_valid = 1'b0;
  logic         mode = 1'b0;
  logic [W-1:0] din = '0;
  logic         in_ready, dout_valid, dout_first, dout_last, busy, overrun;
  logic [3:0]   wen_ctrl, ren_ctrl;
  logic [2:0]   waddr_ctrl, raddr_ctrl;
  logic [1:0]   dbg_state;

  dif_radix2_64p_da_ctrl #(.FRAME_LEN(64), .RD_LAT(1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .mode(mode),
    .wen_ctrl(wen_ctrl), .waddr_ctrl(waddr_ctrl), .ren_ctrl(ren_ctrl), .raddr_ctrl(raddr_ctrl),
    .dout_valid(dout_valid), .dout_first(dout_first), .dout_last(dout_last),
    .busy(busy), .overrun(overrun), .dbg_state(dbg_state)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Output index k of a frame carries the sample written k-th in the
  // source order given by the mode.
  function automatic int src_of(input logic m, input int k);
    int r;
    if (m) return (k % 8) * 8 + k / 8;
    r = 0;
    for (int i = 0; i < 6; i++)
      if (((k >> i) & 1) != 0) r = r | (1 << (5 - i));
    return r;
  endfunction

  // Arranger model: 8x8 memory, one-cycle read latency.
  logic [W-1:0] mem [8][8];
  logic [W-1:0] rdata = '0;
  int wr_count = 0;
  always @(posedge clk) begin
    if (wen_ctrl != 4'd8) begin
      mem[wen_ctrl[2:0]][waddr_ctrl] = din;
      wr_count++;
    end
    if (ren_ctrl != 4'd8) rdata <= mem[ren_ctrl[2:0]][raddr_ctrl];
  end

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int out_idx = 0;
  int rd_idx = 0;
  logic [3:0] ren_log [64];
  logic [2:0] raddr_log [64];

  always @(negedge clk) begin
    if (rst_n) begin
      if (ren_ctrl != 4'd8) begin
        ren_log[rd_idx]   = ren_ctrl;
        raddr_log[rd_idx] = raddr_ctrl;
        rd_idx = (rd_idx + 1) % 64;
      end
      if (dout_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_dout", 32'(dout_valid), 32'(0));
        end else begin
          logic [W-1:0] e;
          e = exp_q.pop_front();
          chk("dout_data", 32'(rdata), 32'(e));
          chk("dout_first", 32'(dout_first), 32'(out_idx == 0));
          chk("dout_last", 32'(dout_last), 32'(out_idx == 63));
          out_idx = (out_idx + 1) % 64;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (busy && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) chk("idle_timeout", 32'(busy), 32'(0));
  endtask

  task automatic wait_drained();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(negedge clk);
      #2;
      n++;
    end
    chk("drain_timeout", 32'(exp_q.size()), 32'(0));
    @(negedge clk);
    #1 chk("busy_after_frame", 32'(busy), 32'(0));
  endtask

  // Drives one complete frame; expectations are queued before any write.
  task automatic send_frame(input logic m, input bit seq_vals, input bit gappy,
                            input bit hold, input bit swap);
    logic [W-1:0] s [64];
    int n, cnt;
    wait_idle();
    wr_count = 0;
    for (int i = 0; i < 64; i++) s[i] = seq_vals ? W'(i) : W'($urandom);
    for (int k = 0; k < 64; k++) exp_q.push_back(s[src_of(m, k)]);
    n = 0;
    while (n < 64) begin
      if (n != 0) @(negedge clk);
      if (gappy && $urandom_range(0, 2) == 0) begin
        in_valid = 1'b0;
        #1 chk("wen_idle_gap", 32'(wen_ctrl), 32'(8));
      end else begin
        in_valid = 1'b1;
        din      = s[n];
        mode     = (swap && n >= 32) ? ~m : m;
        #1;
        chk("in_ready_fill", 32'(in_ready), 32'(1));
        chk("wen_bank", 32'(wen_ctrl), 32'(n / 8));
        chk("waddr", 32'(waddr_ctrl), 32'(n % 8));
        n++;
      end
    end
    if (hold) begin
      chk("overrun_pre", 32'(overrun), 32'(0));
      cnt = 0;
      for (int c = 0; c < 200; c++) begin
        @(negedge clk);
        if (in_ready) break;
        cnt++;
        if (wen_ctrl != 4'd8) chk("no_write_drain", 32'(wen_ctrl), 32'(8));
      end
      in_valid = 1'b0;
      chk("ready_low_cycles", 32'(cnt), 32'(65));
      chk("overrun_set", 32'(overrun), 32'(1));
    end else begin
      @(negedge clk);
      in_valid = 1'b0;
    end
    wait_drained();
    chk("write_count", 32'(wr_count), 32'(64));
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic       mode;
    bit         seq_vals;
    bit         gappy;
    bit         hold;
    bit         swap;
    logic [3:0] exp_ren1;
    logic [2:0] exp_raddr1;
  } vec_t;

  vec_t vecs [6];

  initial begin
    // mode, seq, gappy, hold, swap, second read bank/addr
    vecs[0] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd4, 3'd0};  // bit-reversed
    vecs[1] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd1, 3'd0};  // transpose
    vecs[2] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd4, 3'd0};  // stalls in FILL
    vecs[3] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'd1, 3'd0};  // in_valid held through DRAIN
    vecs[4] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd4, 3'd0};  // mode flips mid-frame
    vecs[5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd1, 3'd0};  // next frame transposed

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_wen", 32'(wen_ctrl), 32'(8));
    chk("rst_ren", 32'(ren_ctrl), 32'(8));
    chk("rst_waddr", 32'(waddr_ctrl), 32'(0));
    chk("rst_raddr", 32'(raddr_ctrl), 32'(0));
    chk("rst_dout_valid", 32'(dout_valid), 32'(0));
    chk("rst_dout_first", 32'(dout_first), 32'(0));
    chk("rst_dout_last", 32'(dout_last), 32'(0));
    chk("rst_overrun", 32'(overrun), 32'(0));
    rst_n = 1'b1;

    for (int v = 0; v < 6; v++) begin
      send_frame(vecs[v].mode, vecs[v].seq_vals, vecs[v].gappy, vecs[v].hold, vecs[v].swap);
      chk("first_read_bank", 32'(ren_log[0]), 32'(0));
      chk("first_read_addr", 32'(raddr_log[0]), 32'(0));
      chk("second_read_bank", 32'(ren_log[1]), 32'(vecs[v].exp_ren1));
      chk("second_read_addr", 32'(raddr_log[1]), 32'(vecs[v].exp_raddr1));
    end

    // Asynchronous reset with 20 samples written
    wait_idle();
    for (int n = 0; n < 20; n++) begin
      if (n != 0) @(negedge clk);
      in_valid = 1'b1;
      din      = W'($urandom);
      mode     = 1'b0;
    end
    @(negedge clk);
    in_valid = 1'b0;
    #1 chk("midframe_busy", 32'(busy), 32'(1));
    rst_n = 1'b0;
    #1;
    chk("async_rst_busy", 32'(busy), 32'(0));
    chk("async_rst_wen", 32'(wen_ctrl), 32'(8));
    chk("async_rst_ren", 32'(ren_ctrl), 32'(8));
    chk("async_rst_waddr", 32'(waddr_ctrl), 32'(0));
    chk("async_rst_overrun", 32'(overrun), 32'(0));
    chk("async_rst_dout_valid", 32'(dout_valid), 32'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    send_frame(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    send_frame(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
